board_controller: RTL and testbench

- Sits directly downstream of the row/column decoder.
- Consumes its 9-bit one-hot cell-select vector and holds the board state as separate X and O occupancy masks.
- Alternates turns, rejects illegal moves, and detects a win or a draw.
- Feeds the display/LED stage and the game-status logic.

---
 rtl/board_pkg.sv | 43 ++++
 rtl/line_checker.sv | 16 +
 rtl/board_controller.sv | 106 ++++++++++
 tb/tb_board_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - cell indices, win-line masks, winner codes and FSM states for board_controller
package board_pkg;

  // Cell index = 8 - (3*(col-1) + row-1)
  localparam int C_R1C1 = 8;
  localparam int C_R2C1 = 7;
  localparam int C_R3C1 = 6;
  localparam int C_R1C2 = 5;
  localparam int C_R2C2 = 4;
  localparam int C_R3C2 = 3;
  localparam int C_R1C3 = 2;
  localparam int C_R2C3 = 1;
  localparam int C_R3C3 = 0;

  localparam logic [8:0] FULL_BOARD = 9'h1FF;

  function automatic logic [8:0] cell_bit(input int idx);
    return 9'(1) << idx;
  endfunction

  localparam logic [8:0] WIN_LINE [0:7] = '{
    cell_bit(C_R1C1) | cell_bit(C_R2C1) | cell_bit(C_R3C1),
    cell_bit(C_R1C2) | cell_bit(C_R2C2) | cell_bit(C_R3C2),
    cell_bit(C_R1C3) | cell_bit(C_R2C3) | cell_bit(C_R3C3),
    cell_bit(C_R1C1) | cell_bit(C_R1C2) | cell_bit(C_R1C3),
    cell_bit(C_R2C1) | cell_bit(C_R2C2) | cell_bit(C_R2C3),
    cell_bit(C_R3C1) | cell_bit(C_R3C2) | cell_bit(C_R3C3),
    cell_bit(C_R1C1) | cell_bit(C_R2C2) | cell_bit(C_R3C3),
    cell_bit(C_R3C1) | cell_bit(C_R2C2) | cell_bit(C_R1C3)
  };

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_X    = 2'b01;
  localparam logic [1:0] W_O    = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    OVER  = 2'd2
  } state_t;

endpackage

// File: rtl/line_checker.sv
// rtl/line_checker.sv - flags every win line fully covered by one player's occupancy mask
import board_pkg::*;

module line_checker (
  input  logic [8:0] mask,
  output logic [7:0] hits,
  output logic       any_win
);

  for (genvar i = 0; i < 8; i++) begin : g_line
    assign hits[i] = ((mask & WIN_LINE[i]) == WIN_LINE[i]);
  end

  assign any_win = |hits;

endmodule

// File: rtl/board_controller.sv
// rtl/board_controller.sv - tic-tac-toe board state, turn alternation, move legality and win/draw detection
import board_pkg::*;

module board_controller #(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] cell_sel,
  input  logic       new_game,
  output logic [8:0] pos_x,
  output logic [8:0] pos_o,
  output logic       turn,
  output logic       illegal,
  output logic [1:0] winner,
  output logic [7:0] win_line,
  output logic       game_over
);

  state_t     state, state_n;
  logic       sel_prev;
  logic [8:0] pos_x_n, pos_o_n;
  logic       turn_n, illegal_n, game_over_n;
  logic [1:0] winner_n;
  logic [7:0] win_line_n;

  logic       request, multi_hot, occupied;
  logic [7:0] x_hits, o_hits;
  logic       x_win, o_win;

  line_checker u_check_x (.mask(pos_x), .hits(x_hits), .any_win(x_win));
  line_checker u_check_o (.mask(pos_o), .hits(o_hits), .any_win(o_win));

  // A held select yields one request; clearing the lowest set bit exposes multi-hot selects
  assign request   = (|cell_sel) && !sel_prev;
  assign multi_hot = |(cell_sel & (cell_sel - 9'd1));
  assign occupied  = |(cell_sel & (pos_x | pos_o));

  always_comb begin
    state_n     = state;
    pos_x_n     = pos_x;
    pos_o_n     = pos_o;
    turn_n      = turn;
    illegal_n   = 1'b0;
    winner_n    = winner;
    win_line_n  = win_line;
    game_over_n = game_over;
    case (state)
      PLAY: begin
        if (request) begin
          if (multi_hot || occupied) begin
            illegal_n = 1'b1;
          end else begin
            if (turn) pos_o_n = pos_o | cell_sel;
            else      pos_x_n = pos_x | cell_sel;
            state_n = CHECK;
          end
        end
      end
      CHECK: begin
        // Only the mover can have just completed a line, and a win outranks a full board
        if (turn ? o_win : x_win) begin
          winner_n    = turn ? W_O : W_X;
          win_line_n  = turn ? o_hits : x_hits;
          game_over_n = 1'b1;
          state_n     = OVER;
        end else if ((pos_x | pos_o) == FULL_BOARD) begin
          winner_n    = W_DRAW;
          game_over_n = 1'b1;
          state_n     = OVER;
        end else begin
          turn_n  = ~turn;
          state_n = PLAY;
        end
      end
      OVER: begin
      end
      default: state_n = PLAY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || new_game) begin
      state     <= PLAY;
      sel_prev  <= 1'b0;
      pos_x     <= '0;
      pos_o     <= '0;
      turn      <= FIRST_PLAYER;
      illegal   <= 1'b0;
      winner    <= W_NONE;
      win_line  <= '0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      sel_prev  <= |cell_sel;
      pos_x     <= pos_x_n;
      pos_o     <= pos_o_n;
      turn      <= turn_n;
      illegal   <= illegal_n;
      winner    <= winner_n;
      win_line  <= win_line_n;
      game_over <= game_over_n;
    end
  end

endmodule

// File: tb/tb_board_controller.sv
// tb/tb_board_controller.sv - randomized and directed self-checking bench for board_controller
module tb_board_controller;

  localparam logic FP = 1'b0;

  logic       clock = 1'b0;
  logic       reset;
  logic [8:0] cell_sel;
  logic       new_game;
  logic [8:0] pos_x, pos_o;
  logic       turn, illegal, game_over;
  logic [1:0] winner;
  logic [7:0] win_line;

  int checks = 0;
  int errors = 0;

  // Reference game: board[i] is 0 empty, 1 X, 2 O
  int         board [9];
  int         m_turn;
  int         m_winner;
  logic [7:0] m_line;
  bit         m_over;

  board_controller #(.FIRST_PLAYER(FP)) dut (
    .clock(clock), .reset(reset), .cell_sel(cell_sel), .new_game(new_game),
    .pos_x(pos_x), .pos_o(pos_o), .turn(turn), .illegal(illegal),
    .winner(winner), .win_line(win_line), .game_over(game_over)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int cidx(int r, int c);
    return 8 - (3 * (c - 1) + r - 1);
  endfunction

  function automatic logic [8:0] m_mask(int p);
    logic [8:0] m = '0;
    for (int i = 0; i < 9; i++) if (board[i] == p) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [7:0] m_lines(int p);
    logic [7:0] h = '0;
    for (int k = 1; k <= 3; k++) begin
      if (board[cidx(1,k)] == p && board[cidx(2,k)] == p && board[cidx(3,k)] == p) h[k-1] = 1'b1;
      if (board[cidx(k,1)] == p && board[cidx(k,2)] == p && board[cidx(k,3)] == p) h[k+2] = 1'b1;
    end
    if (board[cidx(1,1)] == p && board[cidx(2,2)] == p && board[cidx(3,3)] == p) h[6] = 1'b1;
    if (board[cidx(3,1)] == p && board[cidx(2,2)] == p && board[cidx(1,3)] == p) h[7] = 1'b1;
    return h;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 9; i++) board[i] = 0;
    m_turn = int'(FP); m_winner = 0; m_line = '0; m_over = 0;
  endfunction

  task automatic check_status(string tag);
    checks++;
    if (pos_x !== m_mask(1) || pos_o !== m_mask(2)) begin
      errors++;
      $display("FAIL %s masks: got x=%h o=%h want x=%h o=%h", tag, pos_x, pos_o, m_mask(1), m_mask(2));
    end
    checks++;
    if (winner !== 2'(m_winner) || win_line !== m_line || game_over !== m_over) begin
      errors++;
      $display("FAIL %s status: got winner=%b line=%h over=%b want winner=%b line=%h over=%b",
               tag, winner, win_line, game_over, 2'(m_winner), m_line, m_over);
    end
    checks++;
    if (turn !== 1'(m_turn) || illegal !== 1'b0) begin
      errors++;
      $display("FAIL %s turn/illegal: got turn=%b illegal=%b want turn=%b illegal=0", tag, turn, illegal, 1'(m_turn));
    end
  endtask

  task automatic do_move(input logic [8:0] sel, input int hold, input string tag);
    bit exp_ill = 0;
    bit accepted = 0;
    logic [7:0] h;
    cell_sel = sel;
    if (!m_over) begin
      if ($countones(sel) > 1 || (sel & (m_mask(1) | m_mask(2))) != 0) exp_ill = 1;
      else begin
        for (int i = 0; i < 9; i++) if (sel[i]) board[i] = m_turn + 1;
        accepted = 1;
      end
    end
    step();
    checks++;
    if (illegal !== exp_ill || pos_x !== m_mask(1) || pos_o !== m_mask(2)) begin
      errors++;
      $display("FAIL %s edge: got illegal=%b x=%h o=%h want illegal=%b x=%h o=%h",
               tag, illegal, pos_x, pos_o, exp_ill, m_mask(1), m_mask(2));
    end
    if (accepted) begin
      h = m_lines(m_turn + 1);
      if (h != 0) begin
        m_winner = m_turn + 1; m_line = h; m_over = 1;
      end else if ((m_mask(1) | m_mask(2)) == 9'h1FF) begin
        m_winner = 3; m_over = 1;
      end else m_turn = 1 - m_turn;
    end
    if (hold == 1) cell_sel = '0;
    step();
    check_status({tag, "+2"});
    for (int i = 2; i < hold; i++) begin
      step();
      check_status({tag, " held"});
    end
    cell_sel = '0;
    step();
    check_status({tag, " released"});
  endtask

  task automatic start_new(input logic [8:0] sel, input string tag);
    new_game = 1'b1;
    cell_sel = sel;
    step();
    new_game = 1'b0;
    cell_sel = '0;
    model_clear();
    check_status({tag, " clear"});
    step();
    check_status({tag, " after"});
  endtask

  task automatic test_reset();
    reset = 1'b1; new_game = 1'b0; cell_sel = '0;
    step(); step();
    reset = 1'b0;
    model_clear();
    check_status("reset");
  endtask

  task automatic test_held_select();
    do_move(9'h100, 5, "held");
  endtask

  task automatic test_column_win();
    int seq[5] = '{8, 5, 7, 4, 6};
    start_new('0, "colwin");
    foreach (seq[i]) do_move(9'(1) << seq[i], 1, "colwin");
  endtask

  task automatic test_occupied();
    start_new('0, "occ");
    do_move(9'h100, 1, "occ x8");
    do_move(9'h100, 1, "occ o8");
    do_move(9'h010, 2, "occ o4");
  endtask

  task automatic test_multi_hot();
    start_new('0, "multi");
    do_move(9'h003, 1, "multi");
  endtask

  task automatic test_draw();
    int seq[9] = '{8, 5, 7, 6, 3, 4, 2, 1, 0};
    start_new('0, "draw");
    foreach (seq[i]) do_move(9'(1) << seq[i], 1, "draw");
  endtask

  task automatic test_double_win_full();
    int seq[9] = '{8, 5, 6, 3, 2, 1, 0, 7, 4};
    start_new('0, "dbl");
    foreach (seq[i]) do_move(9'(1) << seq[i], 1, "dbl");
  endtask

  task automatic test_over_ignore();
    test_column_win();
    for (int i = 0; i < 3; i++) do_move(9'(1) << $urandom_range(8), 1, "over");
    start_new(9'h010, "over newgame");
  endtask

  task automatic test_random();
    logic [8:0] sel;
    for (int g = 0; g < 25; g++) begin
      start_new('0, "rand");
      for (int m = 0; m < 30 && !m_over; m++) begin
        if ($urandom_range(3) == 0) sel = 9'($urandom_range(1, 511));
        else sel = 9'(1) << $urandom_range(8);
        do_move(sel, int'($urandom_range(1, 3)), "rand");
      end
      if (m_over) do_move(9'(1) << $urandom_range(8), 1, "rand over");
    end
  endtask

  initial begin
    test_reset();
    test_held_select();
    test_column_win();
    test_occupied();
    test_multi_hot();
    test_draw();
    test_double_win_full();
    test_over_ignore();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
